// File: rtl/bike_mult_counter_dec_load.sv
// Loadable down-counter for the BIKE multiplier loops.
// A start pulse loads a clamped start value, then each enabled cycle steps the
// value down to MIN_VALUE. The final value is flagged with last, and done
// pulses once after that final value is consumed.
module bike_mult_counter_dec_load #(
  parameter int SIZE      = 5,
  parameter int INIT      = 20,
  parameter int MIN_VALUE = 0,
  parameter int MAX_VALUE = 20
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [SIZE-1:0] load_value,
  input  logic            enable,
  input  logic            abort,
  output logic [SIZE-1:0] cnt_out,
  output logic            busy,
  output logic            last,
  output logic            done
);

  localparam logic [SIZE-1:0] INIT_V = SIZE'(INIT);
  localparam logic [SIZE-1:0] MIN_V  = SIZE'(MIN_VALUE);
  localparam logic [SIZE-1:0] MAX_V  = SIZE'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] load_clamped;
  logic            at_min;

  // Limit the requested start value to the legal range [MIN_VALUE, MAX_VALUE].
  always_comb begin
    load_clamped = load_value;
    if (load_value < MIN_V)      load_clamped = MIN_V;
    else if (load_value > MAX_V) load_clamped = MAX_V;
  end

  assign at_min = (cnt_q == MIN_V);

  // Next-state and next-count logic. Abort takes priority over start and enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = INIT_V;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_d   = load_clamped;
          state_d = RUN;
        end
        // The decrement is never applied at MIN_VALUE, so the counter cannot wrap.
        RUN: if (enable) begin
          if (at_min) state_d = DONE;
          else        cnt_d   = cnt_q - 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= INIT_V;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = (state_q == RUN);
  assign last    = (state_q == RUN) && at_min;
  assign done    = (state_q == DONE);

endmodule
